vga_timing_controller: RTL

Pixel-timing and output stage of the VGA display path. It generates the pixelX/pixelY scan coordinates consumed by the drawing stages (background, objects, mux), and re-times the 8-bit RGB332 pixel those stages return. It aligns that pixel with delayed hsync/vsync/blank and drives the 4-bit-per-channel VGA DAC pins.

---
 rtl/vga_timing_controller.sv | 119 +++++++++++
 1 files changed

// File: rtl/vga_timing_controller.sv
// VGA scan counters plus sync/blank delay line and RGB332 output stage.
// Pins lag pixelX/pixelY by PIPE_DELAY+1 cycles so they line up with RGB_in.
module vga_timing_controller #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic [7:0]  RGB_in,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        startOfFrame,
   output logic        vgaHS,
   output logic        vgaVS,
   output logic        vgaBlankN,
   output logic [3:0]  vgaR,
   output logic [3:0]  vgaG,
   output logic [3:0]  vgaB
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned TAP     = PIPE_DELAY - 1;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic        h_last;
   logic        v_last;
   logic        visible;
   logic        hs_raw;
   logic        vs_raw;
   logic        vis_tap;

   logic [PIPE_DELAY-1:0] vis_dly;
   logic [PIPE_DELAY-1:0] hs_dly;
   logic [PIPE_DELAY-1:0] vs_dly;

   assign pixelX = h_cnt;
   assign pixelY = v_cnt;

   always_comb begin
      h_last  = (h_cnt == H_LAST);
      v_last  = (v_cnt == V_LAST);
      visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_raw  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vs_raw  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
      vis_tap = vis_dly[TAP];
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         h_cnt        <= '0;
         v_cnt        <= '0;
         startOfFrame <= 1'b0;
      end else begin
         // Registered so the pulse coincides with pixelX=0, pixelY=0.
         startOfFrame <= h_last && v_last;
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 11'd1;
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vis_dly <= '0;
         hs_dly  <= '1;
         vs_dly  <= '1;
      end else begin
         vis_dly[0] <= visible;
         hs_dly[0]  <= hs_raw;
         vs_dly[0]  <= vs_raw;
         for (int i = 1; i < int'(PIPE_DELAY); i++) begin
            vis_dly[i] <= vis_dly[i-1];
            hs_dly[i]  <= hs_dly[i-1];
            vs_dly[i]  <= vs_dly[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         vgaHS     <= 1'b1;
         vgaVS     <= 1'b1;
         vgaBlankN <= 1'b0;
         vgaR      <= 4'h0;
         vgaG      <= 4'h0;
         vgaB      <= 4'h0;
      end else begin
         vgaHS     <= hs_dly[TAP];
         vgaVS     <= vs_dly[TAP];
         vgaBlankN <= vis_tap;
         // Replicate MSBs so full-scale 3/2-bit codes map to 4'hF.
         vgaR      <= vis_tap ? {RGB_in[7:5], RGB_in[7]}   : 4'h0;
         vgaG      <= vis_tap ? {RGB_in[4:2], RGB_in[4]}   : 4'h0;
         vgaB      <= vis_tap ? {RGB_in[1:0], RGB_in[1:0]} : 4'h0;
      end
   end

endmodule
